// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared state encoding, default sizes and width helper for the FIFO write-side controller
package fifo_ctrl_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int DEF_AW = 6;
  localparam int DEF_DEPTH = 2 ** DEF_AW;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder starting just after the last winner
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  // first active request searching upward from rr_last+1 with wrap
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(rr_last) + k) % NREQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
        grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-atomic sharing of the FIFO write port with occupancy tracking
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int AW = DEF_AW,
  parameter int AFULL_TH = 56,
  localparam int IW = clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             fifo_wr,
  output logic [DW-1:0]    fifo_wdata,
  input  logic             fifo_rd,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [IW-1:0]    grant_id,
  output logic             rd_err
);
  localparam int DEPTH = 2 ** AW;
  state_t state, state_nxt;
  logic [IW-1:0] rr_last, owner, win_idx, sel;
  logic [NREQ-1:0] win_grant;
  logic win_any, active, last, rd_eff;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req_valid),
    .rr_last(rr_last),
    .grant(win_grant),
    .idx(win_idx),
    .any(win_any)
  );
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= (AW + 1)'(AFULL_TH);
  assign rd_eff = fifo_rd & ~empty;
  // pick the requester allowed to write: fresh winner when idle, locked owner during a packet
  always_comb begin
    sel = state == BURST ? owner : win_idx;
    active = rst & (state == BURST | win_any) & ~full;
    req_ready = !active ? '0 : state == BURST ? NREQ'(1) << owner : win_grant;
    fifo_wr = |(req_valid & req_ready);
    fifo_wdata = fifo_wr ? req_data[sel*DW +: DW] : '0;
    last = req_last[sel];
  end
  // a non-last beat locks the port, a last beat releases it
  always_comb begin
    state_nxt = fifo_wr ? (last ? IDLE : BURST) : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  // arbitration history, occupancy and sticky underflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last <= IW'(NREQ - 1);
      owner <= '0;
      grant_id <= '0;
      count <= '0;
      rd_err <= 1'b0;
    end else begin
      if (fifo_wr) begin
        grant_id <= sel;
        if (last) rr_last <= sel;
        else owner <= sel;
      end
      if (fifo_wr & ~rd_eff) count <= count + 1'b1;
      else if (rd_eff & ~fifo_wr) count <= count - 1'b1;
      if (fifo_rd & empty) rd_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed table vectors plus hand sequences for full, empty and reset corners
module tb_fifo_wr_arbiter;
  logic clk, rst;
  logic [3:0] req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic fifo_wr, fifo_rd, full, empty, almost_full, rd_err;
  logic [7:0] fifo_wdata;
  logic [6:0] count;
  logic [1:0] grant_id;
  int n_cmp, n_bad, mc;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic rd;
    logic [3:0] rdy;
    logic wr;
    logic [7:0] wd;
    int cnt;
    int gid;
  } vec_t;
  vec_t tbl [17];

  fifo_wr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_rd(fifo_rd),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .grant_id(grant_id), .rd_err(rd_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rd);
    @(negedge clk);
    req_valid = v;
    req_last = l;
    fifo_rd = rd;
    #1;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    req_data = 32'hA3A2A1A0;
    req_valid = 4'hF;
    req_last = 4'hF;
    fifo_rd = 0;
    rst = 0;
    tbl[0]  = '{4'hF, 4'hF, 0, 4'h1, 1, 8'hA0, 1, 0};
    tbl[1]  = '{4'hF, 4'hF, 0, 4'h2, 1, 8'hA1, 2, 1};
    tbl[2]  = '{4'hF, 4'hF, 0, 4'h4, 1, 8'hA2, 3, 2};
    tbl[3]  = '{4'hF, 4'hF, 0, 4'h8, 1, 8'hA3, 4, 3};
    tbl[4]  = '{4'hF, 4'hF, 0, 4'h1, 1, 8'hA0, 5, 0};
    tbl[5]  = '{4'hF, 4'hF, 0, 4'h2, 1, 8'hA1, 6, 1};
    tbl[6]  = '{4'hF, 4'hF, 0, 4'h4, 1, 8'hA2, 7, 2};
    tbl[7]  = '{4'hF, 4'hF, 0, 4'h8, 1, 8'hA3, 8, 3};
    tbl[8]  = '{4'h3, 4'h2, 0, 4'h1, 1, 8'hA0, 9, 0};
    tbl[9]  = '{4'h2, 4'h2, 0, 4'h1, 0, 8'h00, 9, 0};
    tbl[10] = '{4'h3, 4'h2, 0, 4'h1, 1, 8'hA0, 10, 0};
    tbl[11] = '{4'h3, 4'h3, 0, 4'h1, 1, 8'hA0, 11, 0};
    tbl[12] = '{4'h2, 4'h2, 0, 4'h2, 1, 8'hA1, 12, 1};
    tbl[13] = '{4'h4, 4'h4, 1, 4'h4, 1, 8'hA2, 12, 2};
    tbl[14] = '{4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 11, 2};
    tbl[15] = '{4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 10, 2};
    tbl[16] = '{4'h8, 4'h8, 1, 4'h8, 1, 8'hA3, 10, 3};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_rderr", rd_err, 0);
    @(negedge clk);
    req_valid = 0;
    rst = 1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].rd);
      chk($sformatf("v%0d_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("v%0d_wr", i), fifo_wr, tbl[i].wr);
      chk($sformatf("v%0d_wdata", i), fifo_wdata, tbl[i].wd);
      settle();
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_gid", i), grant_id, tbl[i].gid);
      chk($sformatf("v%0d_rderr", i), rd_err, 0);
    end
    mc = 10;
    for (int i = 0; i < 54; i++) begin
      drive(4'hF, 4'hF, 0);
      chk($sformatf("fill%0d_wr", i), fifo_wr, 1);
      settle();
      mc++;
      chk($sformatf("fill%0d_count", i), count, mc);
      chk($sformatf("fill%0d_afull", i), almost_full, mc >= 56 ? 1 : 0);
      chk($sformatf("fill%0d_full", i), full, mc == 64 ? 1 : 0);
    end
    drive(4'hF, 4'hF, 0);
    chk("full_ready", req_ready, 0);
    chk("full_wr", fifo_wr, 0);
    settle();
    chk("full_hold", count, 64);
    drive(4'hF, 4'hF, 1);
    chk("full_rd_ready", req_ready, 0);
    chk("full_rd_wr", fifo_wr, 0);
    settle();
    chk("full_rd_count", count, 63);
    chk("full_rd_full", full, 0);
    chk("full_rd_afull", almost_full, 1);
    drive(4'hF, 4'hF, 0);
    chk("resume_wr", fifo_wr, 1);
    settle();
    chk("resume_count", count, 64);
    chk("resume_full", full, 1);
    mc = 64;
    for (int i = 0; i < 64; i++) begin
      drive(4'h0, 4'h0, 1);
      settle();
      mc--;
      chk($sformatf("drain%0d_count", i), count, mc);
    end
    chk("drain_empty", empty, 1);
    chk("drain_rderr", rd_err, 0);
    drive(4'h1, 4'h1, 1);
    chk("empty_wr", fifo_wr, 1);
    settle();
    chk("empty_wrrd_count", count, 1);
    chk("empty_wrrd_rderr", rd_err, 1);
    drive(4'h0, 4'h0, 1);
    settle();
    chk("rd1_count", count, 0);
    drive(4'h0, 4'h0, 1);
    settle();
    chk("under_count", count, 0);
    chk("under_empty", empty, 1);
    chk("under_rderr", rd_err, 1);
    drive(4'h4, 4'h0, 0);
    chk("b1_ready", req_ready, 4);
    settle();
    drive(4'h4, 4'h0, 0);
    chk("b2_ready", req_ready, 4);
    settle();
    chk("b2_count", count, 2);
    chk("b2_gid", grant_id, 2);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_rderr", rd_err, 0);
    chk("mrst_gid", grant_id, 0);
    @(negedge clk);
    rst = 1;
    req_valid = 4'h5;
    req_last = 4'h5;
    #1;
    chk("post_ready0", req_ready, 1);
    chk("post_wdata0", fifo_wdata, 8'hA0);
    settle();
    chk("post_gid0", grant_id, 0);
    drive(4'h5, 4'h5, 0);
    chk("post_ready2", req_ready, 4);
    settle();
    chk("post_gid2", grant_id, 2);
    chk("post_count", count, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the 64-entry FIFO among NREQ requesters using round-robin arbitration with packet-atomic bursts.
Tracks FIFO occupancy from its own write strobes and the consumer's read strobes, and drives full/empty/almost_full back to the FIFO and to the requesters.
Sits between the producer requesters and the FIFO write-pointer/memory logic; the read side is only observed through fifo_rd.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width per beat
AW, 6, FIFO address width; DEPTH = 2**AW = 64
AFULL_TH, 56, almost_full threshold in entries

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester beat valid
req_last  in  NREQ  per-requester last beat of packet
req_data  in  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
req_ready  out  NREQ  per-requester accept; a beat transfers when valid&ready
fifo_wr  out  1  FIFO write strobe, asserted in the cycle of transfer
fifo_wdata  out  DW  data of the transferring requester
fifo_rd  in  1  consumer read strobe
count  out  AW+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
grant_id  out  clog2(NREQ)  index of the current or last winner
rd_err  out  1  sticky; set when fifo_rd arrives while empty

Behaviour:
- Reset (rst low, async): state=IDLE, rr_last=NREQ-1 (requester 0 has top priority first), count=0, owner=0, grant_id=0, rd_err=0.
- Outputs under reset: req_ready=0, fifo_wr=0, fifo_wdata=0, full=0, empty=1, almost_full=0.
- FSM states: IDLE and BURST.
- IDLE, arbitration:
  - winner = first i with req_valid[i]=1, searching from rr_last+1 upward with wrap modulo NREQ.
  - The winner is selected combinationally in the same cycle; there is no grant latency.
- IDLE, handshake:
  - req_ready[winner] = ~full; every other req_ready bit is 0.
  - No valid request: all ready=0, fifo_wr=0.
- IDLE, on transfer:
  - Last=1: stay in IDLE, rr_last<=winner.
  - Last=0: go to BURST, owner<=winner.
  - grant_id<=winner in either case.
- BURST:
  - Only req_ready[owner] = ~full; other requesters are held off even if valid.
  - On an owner transfer with last=1: go to IDLE, rr_last<=owner.
  - Owner deasserting valid mid-burst: stay in BURST, no transfer.
- fifo_wr = |(req_valid & req_ready). fifo_wdata = req_data of the transferring requester; 0 when fifo_wr=0.
- Handshake rule: a requester holds its data and last stable while valid=1 and ready=0.
- Occupancy, updated on the clock edge:
  - rd_eff = fifo_rd & ~empty.
  - count += 1 when fifo_wr & ~rd_eff.
  - count -= 1 when rd_eff & ~fifo_wr.
  - count unchanged when both or neither occur.
- Full: a write in the same cycle as a read is blocked, because ready is already 0. count goes to DEPTH-1 next cycle, and writes resume the cycle after.
- Empty: fifo_rd is ignored, count stays 0, and rd_err<=1. rd_err clears only on reset.
- A simultaneous write and read while empty counts as a write only; rd_err is set.
- Flags full, empty and almost_full decode combinationally from the count register and have no extra latency.
- count never exceeds DEPTH and never goes below 0.
- Reset asserted mid-burst: the burst is abandoned, the FSM goes to IDLE, count goes to 0. The FIFO pointer logic resets on the same rst.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - state encoding for IDLE and BURST;
  - default DEPTH and AW;
  - the clog2 helper for the grant_id width.
- Sub-module rr_arbiter (inputs: request vector, rr_last; outputs: one-hot grant, index, any):
  - purely combinational rotate-priority-encode;
  - instantiated once;
  - owns no state.
- The FSM, owner/rr_last registers and occupancy counter live in fifo_wr_arbiter.

Test Plan:
1. Round-robin: after reset, all 4 requesters valid with last=1 continuously, no reads. Grants go 0,1,2,3,0,..., one fifo_wr per cycle, count increments 1..8 over 8 cycles.
2. Burst atomicity: req0 sends 3 beats (last on the 3rd) while req1 is valid throughout. req_ready[1]=0 for all 3 cycles; req1 is granted in cycle 4; grant_id=1.
3. Full stall: fill to 64 with no reads. full=1, almost_full asserted at count 56, all ready=0. Then one fifo_rd: count=63, and a write is accepted the next cycle.
4. Simultaneous read and write at count=10: count stays 10. Same stimulus at count=0: count=1 and rd_err=1.
5. Underflow: fifo_rd while empty. count stays 0, rd_err stays 1 until rst low.
6. Reset mid-burst: rst low after beat 2 of a 4-beat burst from req2. State IDLE, count=0, empty=1. After release, req0 and req2 both valid: req0 is granted first.
